note2dds_poly: RTL and testbench
================================

Name: note2dds_poly

Overview:
- Polyphonic, pitch-bend-capable successor to the single-note MIDI-note-to-DDS-increment converter.
- Holds VOICES note registers and one shared signed pitch-bend value.
- A single time-multiplexed engine computes each voice's DDS phase increment in turn: semitone split, octave shift, and linear interpolation between semitones for fractional bend.
- Results stream to the DDS oscillator bank as (voice, increment, valid) updates.

Parameters:
- VOICES, 8, number of voices (2..16); voice index width VW = clog2(VOICES).
- ACC_WIDTH, 32, output phase-increment width; must be >= 20.
- FRAC_BITS, 4, fractional semitone bits of bend (1/16 semitone per LSB).
- BEND_W, 9, signed bend width; default range is -256..+255 LSB (about ±16 semitones).

Ports:
- CLK  in  1  system clock; all state changes on posedge.
- RESET_N  in  1  asynchronous active-low reset.
- NOTE_WE  in  1  note write strobe.
- NOTE_VOICE  in  VW  voice index for the write.
- NOTE_IN  in  7  MIDI note number 0..127.
- BEND  in  BEND_W  signed pitch bend; sampled once per voice computation.
- ADDER_OUT  out  ACC_WIDTH  computed phase increment.
- ADDER_VOICE  out  VW  voice to which ADDER_OUT belongs.
- ADDER_VALID  out  1  one-cycle strobe; consumer latches ADDER_OUT into the ADDER_VOICE slot.

Behaviour:
- Reset (async assert, sync release):
  - all note registers = 0, state = LOAD, voice pointer = 0.
  - ADDER_OUT = 0, ADDER_VOICE = 0, ADDER_VALID = 0.
- Note write:
  - When NOTE_WE=1, the note register NOTE_VOICE <= NOTE_IN on the next edge.
  - A write never stalls the engine.
  - NOTE_VOICE >= VOICES is ignored.
- Base table (octave-top increments, index r = 0..12):
  - 359575, 380957, 403610, 427610, 453037, 479976, 508516, 538754, 570790, 604731, 640691, 678788, 719150.
  - Entry 12 equals 2 × entry 0.
- FSM per voice, in order LOAD -> DIV -> INTERP -> OUT -> LOAD:
  - LOAD (1 cycle):
    - p = NOTE × 2^FRAC_BITS + BEND, computed signed and clamped to [0, 127 × 2^FRAC_BITS].
    - rem = p >> FRAC_BITS; frac = p[FRAC_BITS-1:0]; q = 0.
  - DIV (q+1 cycles): each cycle, if rem >= 12 then rem -= 12 and q += 1; otherwise go to INTERP. Final q is 0..10 and r = rem is 0..11.
  - INTERP (1 cycle): v = T[r] + (((T[r+1] − T[r]) × frac) >> FRAC_BITS). The subtraction is unsigned, 17 bits; the product is truncated.
  - OUT (1 cycle):
    - registers ADDER_OUT = v >> (10 − q), zero-extended to ACC_WIDTH.
    - ADDER_VOICE = current voice; ADDER_VALID = 1 for exactly this cycle.
    - voice pointer increments, wrapping VOICES−1 -> 0.
- Timing:
  - Per-voice latency is q+4 cycles, counting LOAD as cycle 1.
  - A full scan takes the sum over voices of (q+4) cycles; with bend 0 the worst case is 14 × VOICES.
- Boundaries:
  - With bend 0, the output equals the non-interpolated semitone table (frac = 0).
  - r = 11 interpolates toward T[12], the next octave.
- Simultaneous events:
  - A note write to the voice being read in LOAD that same cycle: LOAD uses the old value; the new value is taken on the next scan.
  - A BEND change mid-computation has no effect until the next LOAD.
- Reset mid-computation: the partial result is discarded, no VALID is emitted, and the scan restarts at voice 0.
- Outputs are held between strobes.

Test Plan:
- Reset release, no writes -> voice 0 strobes first, ADDER_OUT = 351 (note 0), at cycle 4; voices then step 0,1,…,7,0 with 4-cycle spacing.
- Write voice 3 = note 69, BEND = 0 -> ADDER_VOICE=3 strobe with ADDER_OUT = 18897; that voice's strobe spacing is 9 cycles.
- Write voice 1 = 127, BEND = 0 -> 538754; with BEND = +255 (clamped) -> still 538754.
- Voice 2 = note 60, BEND = +8 -> 11570. Voice 5 = note 11, BEND = +8 -> 682 (uses T[12]). Voice 0 = note 0, BEND = −16 -> clamp -> 351.
- Write voice 4 on the exact cycle its LOAD occurs -> the old value is reported this scan and the new value the next scan. Assert RESET_N low during DIV -> no strobe, all outputs 0, restart at voice 0.

Source files
------------

// File: rtl/note2dds_poly.sv
// Polyphonic MIDI-note to DDS phase-increment converter with shared signed pitch bend.
// One time-multiplexed engine scans all voices: clamp, divide by 12, interpolate, octave shift.
module note2dds_poly #(
  parameter int unsigned VOICES    = 8,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned FRAC_BITS = 4,
  parameter int unsigned BEND_W    = 9,
  localparam int unsigned VW       = (VOICES > 1) ? $clog2(VOICES) : 1
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     NOTE_WE,
  input  logic [VW-1:0]            NOTE_VOICE,
  input  logic [6:0]               NOTE_IN,
  input  logic signed [BEND_W-1:0] BEND,
  output logic [ACC_WIDTH-1:0]     ADDER_OUT,
  output logic [VW-1:0]            ADDER_VOICE,
  output logic                     ADDER_VALID
);

  localparam int unsigned PW   = 7 + FRAC_BITS;
  localparam int unsigned SW   = ((PW > BEND_W) ? PW : BEND_W) + 2;
  localparam int unsigned PMAX = 127 << FRAC_BITS;

  // Increments for the top octave; entry 12 is one octave above entry 0.
  localparam logic [19:0] TABLE [13] = '{
    20'd359575, 20'd380957, 20'd403610, 20'd427610, 20'd453037, 20'd479976, 20'd508516,
    20'd538754, 20'd570790, 20'd604731, 20'd640691, 20'd678788, 20'd719150
  };

  typedef enum logic [1:0] {StLoad, StDiv, StInterp, StOut} state_e;

  state_e                state_q, state_d;
  logic [VW-1:0]         voice_q, voice_d;
  logic [6:0]            notes_q [VOICES];
  logic [6:0]            rem_q, rem_d;
  logic [FRAC_BITS-1:0]  frac_q, frac_d;
  logic [3:0]            oct_q, oct_d;
  logic [19:0]           v_q, v_d;
  logic [ACC_WIDTH-1:0]  out_q, out_d;
  logic [VW-1:0]         out_voice_q, out_voice_d;
  logic                  valid_q, valid_d;

  logic signed [SW-1:0]  p_raw;
  logic [PW-1:0]         p_clamp;
  logic [19:0]           t_lo, t_hi;
  logic [16:0]           t_diff;
  logic [16+FRAC_BITS:0] t_prod;
  logic [3:0]            shift;

  always_comb begin
    p_raw = $signed({{(SW-PW){1'b0}}, notes_q[voice_q], {FRAC_BITS{1'b0}}}) + SW'(BEND);
    if (p_raw[SW-1]) begin
      p_clamp = '0;
    end else if (p_raw > $signed(SW'(PMAX))) begin
      p_clamp = PW'(PMAX);
    end else begin
      p_clamp = p_raw[PW-1:0];
    end
  end

  always_comb begin
    t_lo   = TABLE[rem_q[3:0]];
    t_hi   = TABLE[rem_q[3:0] + 4'd1];
    t_diff = 17'(t_hi - t_lo);
    t_prod = (17 + FRAC_BITS)'(t_diff) * (17 + FRAC_BITS)'(frac_q);
    shift  = 4'd10 - oct_q;
  end

  always_comb begin
    state_d     = state_q;
    voice_d     = voice_q;
    rem_d       = rem_q;
    frac_d      = frac_q;
    oct_d       = oct_q;
    v_d         = v_q;
    out_d       = out_q;
    out_voice_d = out_voice_q;
    valid_d     = 1'b0;
    unique case (state_q)
      StLoad: begin
        rem_d   = p_clamp[PW-1:FRAC_BITS];
        frac_d  = p_clamp[FRAC_BITS-1:0];
        oct_d   = 4'd0;
        state_d = StDiv;
      end
      StDiv: begin
        if (rem_q >= 7'd12) begin
          rem_d = rem_q - 7'd12;
          oct_d = oct_q + 4'd1;
        end else begin
          state_d = StInterp;
        end
      end
      StInterp: begin
        v_d     = t_lo + 20'(t_prod >> FRAC_BITS);
        state_d = StOut;
      end
      StOut: begin
        out_d       = ACC_WIDTH'(v_q >> shift);
        out_voice_d = voice_q;
        valid_d     = 1'b1;
        voice_d     = (32'(voice_q) == VOICES - 1) ? '0 : voice_q + VW'(1);
        state_d     = StLoad;
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= StLoad;
      voice_q     <= '0;
      rem_q       <= '0;
      frac_q      <= '0;
      oct_q       <= '0;
      v_q         <= '0;
      out_q       <= '0;
      out_voice_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      voice_q     <= voice_d;
      rem_q       <= rem_d;
      frac_q      <= frac_d;
      oct_q       <= oct_d;
      v_q         <= v_d;
      out_q       <= out_d;
      out_voice_q <= out_voice_d;
      valid_q     <= valid_d;
    end
  end

  // LOAD samples the pre-edge contents, so a same-cycle write lands on the next scan.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < VOICES; i++) notes_q[i] <= '0;
    end else if (NOTE_WE && (32'(NOTE_VOICE) < VOICES)) begin
      notes_q[NOTE_VOICE] <= NOTE_IN;
    end
  end

  assign ADDER_OUT   = out_q;
  assign ADDER_VOICE = out_voice_q;
  assign ADDER_VALID = valid_q;

endmodule

// File: tb/tb_note2dds_poly.sv
// Directed and randomized bench for note2dds_poly against an arithmetic reference model.
module tb_note2dds_poly;

  localparam int VOICES = 8;
  localparam int TBL [13] = '{359575, 380957, 403610, 427610, 453037, 479976, 508516,
                              538754, 570790, 604731, 640691, 678788, 719150};

  logic              CLK = 1'b0;
  logic              RESET_N;
  logic              NOTE_WE;
  logic [2:0]        NOTE_VOICE;
  logic [6:0]        NOTE_IN;
  logic signed [8:0] BEND;
  logic [31:0]       ADDER_OUT;
  logic [2:0]        ADDER_VOICE;
  logic              ADDER_VALID;

  int n_pass, n_total, n_fail;
  int model_note [VOICES];
  int cur_bend;
  int got_out [VOICES];
  int got_cyc [VOICES];

  note2dds_poly dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .NOTE_WE     (NOTE_WE),
    .NOTE_VOICE  (NOTE_VOICE),
    .NOTE_IN     (NOTE_IN),
    .BEND        (BEND),
    .ADDER_OUT   (ADDER_OUT),
    .ADDER_VOICE (ADDER_VOICE),
    .ADDER_VALID (ADDER_VALID)
  );

  always #5 CLK = ~CLK;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int clamp_p(input int note, input int bend);
    int p;
    p = note * 16 + bend;
    if (p < 0) p = 0;
    if (p > 127 * 16) p = 127 * 16;
    return p;
  endfunction

  function automatic int model_out(input int note, input int bend);
    int p, semi, frac, q, r, v;
    p    = clamp_p(note, bend);
    semi = p / 16;
    frac = p % 16;
    q    = semi / 12;
    r    = semi % 12;
    v    = TBL[r] + ((TBL[r+1] - TBL[r]) * frac) / 16;
    return v / (1 << (10 - q));
  endfunction

  function automatic int model_lat(input int note, input int bend);
    return (clamp_p(note, bend) / 16) / 12 + 4;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Cycles counted from the call up to and including the edge that raises the strobe.
  task automatic wait_strobe(output int cyc, output logic [2:0] v, output logic [31:0] o);
    cyc = 0;
    do begin
      @(posedge CLK); #1;
      cyc++;
    end while (!ADDER_VALID && cyc < 200);
    v = ADDER_VOICE;
    o = ADDER_OUT;
  endtask

  task automatic wait_voice(input string tag, input int want);
    int cyc, guard;
    logic [2:0] v;
    logic [31:0] o;
    guard = 0;
    do begin
      wait_strobe(cyc, v, o);
      guard++;
    end while (v !== 3'(want) && guard < 2 * VOICES + 2);
    chk({tag, " sync"}, v, want);
  endtask

  task automatic write_note(input int v, input int n);
    NOTE_WE = 1'b1; NOTE_VOICE = 3'(v); NOTE_IN = 7'(n);
    @(posedge CLK); #1;
    NOTE_WE = 1'b0;
    model_note[v] = n;
  endtask

  // Skip the scan in flight, then check one whole scan against the model.
  task automatic check_scan(input string tag);
    int cyc;
    logic [2:0] v;
    logic [31:0] o;
    wait_voice(tag, VOICES - 1);
    for (int i = 0; i < VOICES; i++) begin
      wait_strobe(cyc, v, o);
      chk($sformatf("%s voice[%0d]", tag, i), v, i);
      chk($sformatf("%s out[%0d]", tag, i), o, model_out(model_note[i], cur_bend));
      chk($sformatf("%s spacing[%0d]", tag, i), cyc, model_lat(model_note[i], cur_bend));
      got_out[i] = int'(o);
      got_cyc[i] = cyc;
    end
  endtask

  initial begin
    int cyc;
    logic [2:0] v;
    logic [31:0] o;
    n_pass = 0; n_total = 0; n_fail = 0;
    RESET_N = 1'b1; NOTE_WE = 1'b0; NOTE_VOICE = '0; NOTE_IN = '0; BEND = '0;
    cur_bend = 0;
    for (int i = 0; i < VOICES; i++) model_note[i] = 0;

    #2 RESET_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset out", ADDER_OUT, 0);
    chk("reset voice", ADDER_VOICE, 0);
    chk("reset valid", ADDER_VALID, 0);
    RESET_N = 1'b1;

    // First scan: all notes 0, 4-cycle cadence starting at voice 0.
    wait_strobe(cyc, v, o);
    chk("first latency", cyc, 4);
    chk("first voice", v, 0);
    chk("first out", o, 351);
    for (int i = 1; i <= VOICES; i++) begin
      wait_strobe(cyc, v, o);
      chk($sformatf("idle voice step %0d", i), v, i % VOICES);
      chk($sformatf("idle out step %0d", i), o, 351);
      chk($sformatf("idle spacing step %0d", i), cyc, 4);
    end

    write_note(3, 69);
    write_note(1, 127);
    write_note(2, 60);
    write_note(5, 11);
    write_note(4, 40);
    check_scan("bend0");
    chk("note69 out", got_out[3], 18897);
    chk("note69 spacing", got_cyc[3], 9);
    chk("note127 out", got_out[1], 538754);
    chk("note0 out", got_out[0], 351);

    BEND = 9'sd8; cur_bend = 8;
    check_scan("bend+8");
    chk("note60 bend8", got_out[2], 11570);
    chk("note11 bend8 T12", got_out[5], 682);

    BEND = 9'sd255; cur_bend = 255;
    check_scan("bend+255");
    chk("note127 clamp", got_out[1], 538754);

    BEND = -9'sd16; cur_bend = -16;
    check_scan("bend-16");
    chk("note0 clamp low", got_out[0], 351);

    // Write voice 4 during its own LOAD cycle.
    BEND = '0; cur_bend = 0;
    check_scan("settle");
    wait_voice("pre-collide", 3);
    NOTE_WE = 1'b1; NOTE_VOICE = 3'd4; NOTE_IN = 7'd100;
    @(posedge CLK); #1;
    NOTE_WE = 1'b0;
    wait_strobe(cyc, v, o);
    chk("collide voice", v, 4);
    chk("collide old out", o, model_out(40, 0));
    model_note[4] = 100;
    wait_voice("collide next", 4);
    chk("collide new out", ADDER_OUT, model_out(100, 0));

    // Reset while voice 3 (note 69) is dividing.
    wait_voice("pre-reset", 2);
    repeat (2) begin
      @(posedge CLK); #1;
    end
    RESET_N = 1'b0;
    #1;
    chk("midreset out", ADDER_OUT, 0);
    chk("midreset voice", ADDER_VOICE, 0);
    chk("midreset valid", ADDER_VALID, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk($sformatf("midreset hold valid %0d", i), ADDER_VALID, 0);
    end
    RESET_N = 1'b1;
    for (int i = 0; i < VOICES; i++) model_note[i] = 0;
    wait_strobe(cyc, v, o);
    chk("restart latency", cyc, 4);
    chk("restart voice", v, 0);
    chk("restart out", o, 351);
    check_scan("post-reset");

    for (int b = 0; b < 4; b++) begin
      cur_bend = int'($urandom_range(0, 511)) - 256;
      BEND = 9'(cur_bend);
      for (int i = 0; i < VOICES; i++) write_note(i, int'($urandom_range(0, 127)));
      check_scan($sformatf("rand%0d", b));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
